// File: rtl/cap_touch_scanner.sv
// Multi-channel capacitive touch scanner: discharges each pad, times its charge-up,
// calibrates per-pad baselines after reset and produces debounced touch flags.
module cap_touch_scanner #(
    parameter int CHANNELS         = 4,
    parameter int COUNT_W          = 8,
    parameter int DISCHARGE_CYCLES = 8,
    parameter int TIMEOUT          = 255,
    parameter int THRESHOLD        = 20,
    parameter int HYST             = 5,
    parameter int CAL_SCANS        = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [CHANNELS-1:0] pad_in,
    output logic [CHANNELS-1:0] pad_oe,
    output logic [CHANNELS-1:0] pad_out,
    output logic [CHANNELS-1:0] touched,
    output logic                calibrated,
    output logic                count_valid,
    output logic [COUNT_W-1:0]  count_out,
    output logic [2:0]          count_ch,
    output logic                timeout
);

    localparam int CH_W   = (CHANNELS < 2) ? 1 : $clog2(CHANNELS);
    localparam int DIS_W  = (DISCHARGE_CYCLES < 2) ? 1 : $clog2(DISCHARGE_CYCLES);
    localparam int SCAN_W = (CAL_SCANS < 2) ? 1 : $clog2(CAL_SCANS + 1);

    localparam logic [CH_W-1:0]    CH_LAST   = CH_W'(CHANNELS - 1);
    localparam logic [DIS_W-1:0]   DIS_LAST  = DIS_W'(DISCHARGE_CYCLES - 1);
    localparam logic [SCAN_W-1:0]  SCAN_DONE = SCAN_W'(CAL_SCANS);
    localparam logic [COUNT_W-1:0] LIMIT     = COUNT_W'(TIMEOUT);
    localparam logic [COUNT_W:0]   LIMIT_X   = (COUNT_W + 1)'(TIMEOUT);
    localparam logic [COUNT_W:0]   THRESH_X  = (COUNT_W + 1)'(THRESHOLD);
    localparam logic [COUNT_W:0]   HYST_X    = (COUNT_W + 1)'(HYST);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DISCHARGE,
        S_MEASURE,
        S_EVAL,
        S_NEXT
    } state_t;

    state_t state, state_next;

    logic [CH_W-1:0]     ch;
    logic [DIS_W-1:0]    dcnt;
    logic [COUNT_W-1:0]  cnt;
    logic                to_flag;
    logic [SCAN_W-1:0]   scans;
    logic [CHANNELS-1:0] sync1, sync2;
    logic [COUNT_W-1:0]  baseline [CHANNELS];

    logic                pad_high;
    logic                at_limit;
    logic                calibrating;
    logic [COUNT_W:0]    assert_raw, release_raw;
    logic [COUNT_W-1:0]  assert_lvl, release_lvl;

    assign pad_out     = '0;
    assign pad_high    = sync2[ch];
    assign at_limit    = (cnt == LIMIT);
    assign calibrating = (scans != SCAN_DONE);
    assign calibrated  = ~calibrating;

    // Levels are formed one bit wider so baseline+THRESHOLD cannot wrap before saturation.
    always_comb begin
        assert_raw  = {1'b0, baseline[ch]} + THRESH_X;
        release_raw = assert_raw - HYST_X;
        assert_lvl  = (assert_raw > LIMIT_X) ? LIMIT : assert_raw[COUNT_W-1:0];
        release_lvl = (release_raw > LIMIT_X) ? LIMIT : release_raw[COUNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        pad_oe     = '1;
        case (state)
            S_IDLE: begin
                if (enable) begin
                    state_next = S_DISCHARGE;
                end
            end
            S_DISCHARGE: begin
                if (dcnt == DIS_LAST) begin
                    state_next = S_MEASURE;
                end
            end
            S_MEASURE: begin
                pad_oe[ch] = 1'b0;
                if (pad_high || at_limit) begin
                    state_next = S_EVAL;
                end
            end
            S_EVAL: begin
                state_next = S_NEXT;
            end
            S_NEXT: begin
                state_next = enable ? S_DISCHARGE : S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ch          <= '0;
            dcnt        <= '0;
            cnt         <= '0;
            to_flag     <= 1'b0;
            scans       <= '0;
            sync1       <= '0;
            sync2       <= '0;
            baseline    <= '{default: '1};
            touched     <= '0;
            count_valid <= 1'b0;
            count_out   <= '0;
            count_ch    <= '0;
            timeout     <= 1'b0;
        end else begin
            sync1       <= pad_in;
            sync2       <= sync1;
            count_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    ch   <= '0;
                    dcnt <= '0;
                end
                S_DISCHARGE: begin
                    if (dcnt == DIS_LAST) begin
                        dcnt <= '0;
                        cnt  <= '0;
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                end
                S_MEASURE: begin
                    // The exit cycle does not count, so a pad high at release reads 2.
                    if (pad_high || at_limit) begin
                        to_flag <= at_limit && !pad_high;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_EVAL: begin
                    count_valid <= 1'b1;
                    count_out   <= cnt;
                    count_ch    <= 3'(ch);
                    timeout     <= to_flag;
                    if (calibrating) begin
                        touched[ch] <= 1'b0;
                        if (!to_flag && (cnt < baseline[ch])) begin
                            baseline[ch] <= cnt;
                        end
                    end else if (to_flag || (cnt >= assert_lvl)) begin
                        touched[ch] <= 1'b1;
                    end else if (cnt < release_lvl) begin
                        touched[ch] <= 1'b0;
                    end
                end
                S_NEXT: begin
                    dcnt <= '0;
                    if (ch == CH_LAST) begin
                        ch <= '0;
                        if (calibrating) begin
                            scans <= scans + 1'b1;
                        end
                    end else begin
                        ch <= ch + 1'b1;
                    end
                end
                default: begin
                    dcnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cap_touch_scanner.sv
// Directed bench for cap_touch_scanner with a per-pad RC delay model.
module tb_cap_touch_scanner;

    localparam int NEVER = 1000000;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [3:0] pad_in;
    logic [3:0] pad_oe;
    logic [3:0] pad_out;
    logic [3:0] touched;
    logic       calibrated;
    logic       count_valid;
    logic [7:0] count_out;
    logic [2:0] count_ch;
    logic       timeout;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int delay  [4];
    int lowcnt [4];

    cap_touch_scanner #(
        .CHANNELS        (4),
        .COUNT_W         (8),
        .DISCHARGE_CYCLES(8),
        .TIMEOUT         (255),
        .THRESHOLD       (20),
        .HYST            (5),
        .CAL_SCANS       (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .pad_in     (pad_in),
        .pad_oe     (pad_oe),
        .pad_out    (pad_out),
        .touched    (touched),
        .calibrated (calibrated),
        .count_valid(count_valid),
        .count_out  (count_out),
        .count_ch   (count_ch),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A pad reads high once it has been released for delay[i] full cycles.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 4; i++) begin
            lowcnt[i] <= pad_oe[i] ? 0 : lowcnt[i] + 1;
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            pad_in[i] = (pad_oe[i] === 1'b0) && (lowcnt[i] >= delay[i]);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_strobe();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            @(negedge clk);
            if (count_valid === 1'b1) seen = 1'b1;
        end
        check("strobe_seen", 32'(seen), 32'd1);
    endtask

    task automatic expect_meas(input int chn, input int cnt, input int to, input logic [3:0] tch);
        wait_strobe();
        check("count_ch", 32'(count_ch), 32'(chn));
        check("count_out", 32'(count_out), 32'(cnt));
        check("timeout", 32'(timeout), 32'(to));
        check("touched", 32'(touched), 32'(tch));
    endtask

    task automatic wait_oe(input logic [3:0] pattern);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            @(negedge clk);
            if (pad_oe === pattern) seen = 1'b1;
        end
        check("oe_pattern_seen", 32'(seen), 32'd1);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_pad_oe"}, 32'(pad_oe), 32'hF);
        check({tag, "_pad_out"}, 32'(pad_out), 32'h0);
        check({tag, "_touched"}, 32'(touched), 32'h0);
        check({tag, "_calibrated"}, 32'(calibrated), 32'h0);
        check({tag, "_count_valid"}, 32'(count_valid), 32'h0);
        check({tag, "_count_out"}, 32'(count_out), 32'h0);
        check({tag, "_count_ch"}, 32'(count_ch), 32'h0);
        check({tag, "_timeout"}, 32'(timeout), 32'h0);
    endtask

    initial begin
        int prev;
        int strobes;
        for (int i = 0; i < 4; i++) delay[i] = 10;
        reset  = 1'b1;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state("rst");

        // Calibration: two scans at count 12, 23 cycles per channel slot.
        reset  = 1'b0;
        enable = 1'b1;
        prev   = 0;
        for (int i = 0; i < 8; i++) begin
            expect_meas(i % 4, 12, 0, 4'b0000);
            check("cal_flag_during", 32'(calibrated), 32'd0);
            if (i > 0) check("slot_period", 32'(cyc - prev), 32'd23);
            prev = cyc;
        end
        @(negedge clk);
        check("cal_flag_after", 32'(calibrated), 32'd1);

        // Touch on pad 2 at exactly the assert level.
        delay[2] = 30;
        expect_meas(0, 12, 0, 4'b0000);
        expect_meas(1, 12, 0, 4'b0000);
        expect_meas(2, 32, 0, 4'b0100);
        expect_meas(3, 12, 0, 4'b0100);

        // Hysteresis band holds, below release clears.
        delay[2] = 26;
        expect_meas(0, 12, 0, 4'b0100);
        expect_meas(1, 12, 0, 4'b0100);
        expect_meas(2, 28, 0, 4'b0100);
        delay[2] = 24;
        expect_meas(3, 12, 0, 4'b0100);
        expect_meas(0, 12, 0, 4'b0100);
        expect_meas(1, 12, 0, 4'b0100);
        expect_meas(2, 26, 0, 4'b0000);

        // Pad 1 never charges: timeout sets touch, normal count releases it.
        delay[2] = 10;
        delay[1] = NEVER;
        expect_meas(3, 12, 0, 4'b0000);
        expect_meas(0, 12, 0, 4'b0000);
        expect_meas(1, 255, 1, 4'b0010);
        delay[1] = 10;
        expect_meas(2, 12, 0, 4'b0010);
        expect_meas(3, 12, 0, 4'b0010);
        expect_meas(0, 12, 0, 4'b0010);
        expect_meas(1, 12, 0, 4'b0000);

        // Drop enable mid-measurement of pad 1.
        expect_meas(2, 12, 0, 4'b0000);
        expect_meas(3, 12, 0, 4'b0000);
        expect_meas(0, 12, 0, 4'b0000);
        wait_oe(4'b1101);
        enable = 1'b0;
        expect_meas(1, 12, 0, 4'b0000);
        strobes = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (count_valid === 1'b1) strobes++;
        end
        check("idle_no_strobe", 32'(strobes), 32'd0);
        check("idle_pad_oe", 32'(pad_oe), 32'hF);
        check("idle_keeps_cal", 32'(calibrated), 32'd1);
        enable = 1'b1;
        expect_meas(0, 12, 0, 4'b0000);

        // Reset in the middle of pad 3's measurement, with pad 2 touched.
        delay[2] = 30;
        expect_meas(1, 12, 0, 4'b0000);
        expect_meas(2, 32, 0, 4'b0100);
        wait_oe(4'b0111);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_state("midrst");
        reset    = 1'b0;
        delay[2] = 10;
        for (int i = 0; i < 8; i++) begin
            expect_meas(i % 4, 12, 0, 4'b0000);
            check("recal_flag_during", 32'(calibrated), 32'd0);
        end
        @(negedge clk);
        check("recal_flag_after", 32'(calibrated), 32'd1);

        // Rebuilt baseline of 12 makes count 32 a touch again.
        delay[2] = 30;
        expect_meas(0, 12, 0, 4'b0000);
        expect_meas(1, 12, 0, 4'b0000);
        expect_meas(2, 32, 0, 4'b0100);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
